nes_cpu_bus_master: RTL
=======================

# nes_cpu_bus_master

Cartridge-facing NES CPU bus initiator. It generates the console side of the CPU bus that the multicart mapper logic responds to: a continuous M2 clock, /ROMSEL, R/W, A14..A0 and a bidirectional data bus. One request per CPU cycle is taken from a valid/ready port and turned into a correctly phased bus cycle. It sits in the bench and dumper/programmer fixtures, where it drives the cartridge's mapper registers, flash and SRAM exactly as a CPU would.

## Interface
Parameters:
- CYCLE_CLKS, 12: clk periods per CPU cycle; legal range 6..63. The default gives 1.79 MHz from 21.477 MHz.
- M2_LOW_CLKS, 5: clk periods with M2 low at the start of each cycle; legal range 2..CYCLE_CLKS-2.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  a request is present.
- req_ready  out  1  request accepted on the clk where req_valid & req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  16  CPU address; bit 15 selects /ROMSEL.
- req_wdata  in  8  write data.
- resp_valid  out  1  one-clk completion pulse, for both reads and writes.
- resp_rdata  out  8  read data; updated only by reads.
- m2  out  1  CPU M2 clock.
- romsel  out  1  /ROMSEL, active low.
- cpu_rw_in  out  1  R/W to the cartridge; 1 = read.
- cpu_addr_in  out  15  A14..A0.
- cpu_data_out  out  8  write data driven onto the bus.
- cpu_data_oe  out  1  tri-state enable for cpu_data_out.
- cpu_data_in  in  8  bus data as seen from the console side.
- irq  in  1  cartridge /IRQ, active low.
- irq_level  out  1  synchronized IRQ status; see Configuration.

## Operation
- Phase counter `ph` runs 0..CYCLE_CLKS-1, wraps, and is free-running out of reset. M2 therefore toggles continuously, because mapper logic counts M2 edges.
- m2 = 0 for ph < M2_LOW_CLKS and 1 otherwise. It is a registered output and is glitch-free.
- req_ready = 1 only when ph == CYCLE_CLKS-1. An accepted request is latched and executed in the next CPU cycle (the "active" cycle). If no request is accepted, that cycle is an idle cycle.
- Active cycle:
  - At ph == 1: cpu_addr_in = req_addr[14:0] and cpu_rw_in = ~req_write are loaded and held until ph == 1 of the following cycle. This gives one clk of address hold after the M2 fall.
  - romsel = ~(m2 & A15), evaluated from registered state, so it is low only while M2 is high and A15 = 1.
  - Write: cpu_data_out = req_wdata; cpu_data_oe = 1 for ph in M2_LOW_CLKS..CYCLE_CLKS-1 and 0 at ph == 0.
  - Read: cpu_data_in is sampled at ph == CYCLE_CLKS-1, the last clk with M2 high; cpu_data_oe stays 0.
- Idle cycle: cpu_rw_in = 1, address holds its last value, romsel = 1 throughout, cpu_data_oe = 0, and no resp_valid pulse.
- State machine, evaluated at the wrap: IDLE ↔ ACTIVE_RD / ACTIVE_WR. The next state is chosen at ph == CYCLE_CLKS-1 from the handshake, so back-to-back requests give back-to-back active cycles with no gap.

## Timing
- resp_valid pulses at ph == 0 of the cycle after the active cycle; resp_rdata is valid on the same clk.
- Latency from acceptance to resp_valid is 1 + CYCLE_CLKS clks. Peak throughput is one request per CYCLE_CLKS clks.
- Reset values: ph = 0, m2 = 0, romsel = 1, cpu_rw_in = 1, cpu_addr_in = 15'h7FFF, cpu_data_out = 0, cpu_data_oe = 0, req_ready = 0, resp_valid = 0, resp_rdata = 0, irq_level = 0.
- Reset asserted mid-cycle: everything returns asynchronously to the reset values, the in-flight request is dropped, and no resp_valid is produced.
- First req_ready after reset release comes at ph == CYCLE_CLKS-1 of the first cycle.
- req_valid deasserted while req_ready = 0 has no effect; the port keeps no request memory.

## Configuration
- CPU_BUS_MASTER_IRQ_EN defined:
  - irq passes through a 2-flop synchronizer.
  - irq_level = ~sync_irq is registered at ph == CYCLE_CLKS-1, i.e. updated once per CPU cycle, matching when a CPU samples /IRQ.
- Not defined: irq is unused and irq_level is tied to 0.

## Test plan
- Free-run after reset, CYCLE_CLKS = 12, M2_LOW_CLKS = 5, no requests → m2 has period 12 clk with 7 clk high; romsel stays 1; cpu_rw_in stays 1; resp_valid never pulses.
- Write 0x8000 ← 0x5A → cpu_addr_in = 0x0000 and cpu_rw_in = 0 from ph 1; romsel low exactly while m2 = 1; cpu_data_oe high for ph 5..11 with 0x5A; resp_valid 13 clk after acceptance.
- Read 0x6002 with cpu_data_in = 0xC3 at ph 11 and 0x00 elsewhere → romsel stays 1; resp_rdata = 0xC3; cpu_data_oe never asserts.
- Four back-to-back requests, req_valid held high → four consecutive active cycles, no idle cycle between them; four resp_valid pulses spaced 12 clk apart.
- rst_n pulsed low at ph 7 of an active write → all outputs at reset values immediately; no resp_valid; m2 resumes from ph 0.
- With CPU_BUS_MASTER_IRQ_EN defined, irq driven low mid-cycle → irq_level rises at the first ph 11 that is at least 2 clk after the fall; without the macro, irq_level stays 0.

Source files
------------

// File: rtl/nes_cpu_bus_master.sv
// NES CPU bus initiator: free-running M2 phase generator that turns one valid/ready
// request per CPU cycle into a phased cartridge bus cycle. Optional IRQ sampling: CPU_BUS_MASTER_IRQ_EN.
module nes_cpu_bus_master #(
  parameter int unsigned CYCLE_CLKS  = 12,
  parameter int unsigned M2_LOW_CLKS = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        resp_valid,
  output logic [7:0]  resp_rdata,
  output logic        m2,
  output logic        romsel,
  output logic        cpu_rw_in,
  output logic [14:0] cpu_addr_in,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_data_oe,
  input  logic [7:0]  cpu_data_in,
  input  logic        irq,
  output logic        irq_level
);

  localparam int unsigned PW = $clog2(CYCLE_CLKS);
  localparam logic [PW-1:0] PH_LAST = PW'(CYCLE_CLKS - 1);
  localparam logic [PW-1:0] PH_M2   = PW'(M2_LOW_CLKS);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE_RD,
    ACTIVE_WR
  } state_t;

  state_t          state, state_next;
  logic [PW-1:0]   ph, ph_next;
  logic            ph_last;
  logic            accept;
  logic [15:0]     lat_addr;
  logic [7:0]      data_q;
  logic            a15_q;

  always_comb begin
    ph_last    = (ph == PH_LAST);
    accept     = req_valid & ph_last;
    ph_next    = ph_last ? '0 : ph + 1'b1;
    state_next = state;
    if (ph_last) begin
      if (accept) state_next = req_write ? ACTIVE_WR : ACTIVE_RD;
      else        state_next = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph          <= '0;
      m2          <= 1'b0;
      lat_addr    <= '0;
      data_q      <= '0;
      a15_q       <= 1'b0;
      cpu_addr_in <= '1;
      cpu_rw_in   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
    end else begin
      ph         <= ph_next;
      m2         <= (ph_next >= PH_M2);
      resp_valid <= ph_last && (state != IDLE);
      if (accept) begin
        lat_addr <= req_addr;
        if (req_write) data_q <= req_wdata;
      end
      // Bus address/direction change one clk after the M2 fall, giving address hold.
      if (ph == '0) begin
        if (state != IDLE) begin
          cpu_addr_in <= lat_addr[14:0];
          a15_q       <= lat_addr[15];
          cpu_rw_in   <= (state == ACTIVE_RD);
        end else begin
          a15_q     <= 1'b0;
          cpu_rw_in <= 1'b1;
        end
      end
      if (ph_last && (state == ACTIVE_RD)) resp_rdata <= cpu_data_in;
    end
  end

  assign req_ready    = ph_last;
  assign romsel       = ~(m2 & a15_q);
  assign cpu_data_out = data_q;
  assign cpu_data_oe  = (state == ACTIVE_WR) && (ph >= PH_M2);

`ifdef CPU_BUS_MASTER_IRQ_EN
  logic [1:0] irq_sync;

  // Level is sampled once per CPU cycle, at the same point a real CPU polls /IRQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_sync  <= '1;
      irq_level <= 1'b0;
    end else begin
      irq_sync <= {irq_sync[0], irq};
      if (ph_last) irq_level <= ~irq_sync[1];
    end
  end
`else
  logic unused_irq;
  assign unused_irq = irq;
  assign irq_level  = 1'b0;
`endif

endmodule
